gpio_ctrl: RTL

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl_pkg.sv | 20 ++
 rtl/gpio_sync.sv | 25 ++
 rtl/gpio_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO controller: bus width, register window size
// and the word-index encoding of the register map.
package gpio_ctrl_pkg;

  localparam int MXLEN        = 32;
  localparam int WINDOW_BYTES = 32;

  // Register index is the word offset within the window (byte offset >> 2).
  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_DIR  = 3'd1,
    REG_IN   = 3'd2,
    REG_IE   = 3'd3,
    REG_EDGE = 3'd4,
    REG_PEND = 3'd5,
    REG_SET  = 3'd6,
    REG_CLR  = 3'd7
  } reg_sel_e;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH x STAGES flop synchronizer for asynchronous pin inputs; all stages
// clear on synchronous reset so no stale level survives it.
module gpio_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output/direction registers, synchronized inputs,
// per-pin edge capture into a W1C pending register and a level interrupt.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int          NUM_PINS    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [MXLEN-1:0]    addr,
  input  logic [MXLEN-1:0]    w_data,
  input  logic                store,
  input  logic                load,
  output logic [MXLEN-1:0]    r_data,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  logic [NUM_PINS-1:0] out_q;
  logic [NUM_PINS-1:0] dir_q;
  logic [NUM_PINS-1:0] ie_q;
  logic [NUM_PINS-1:0] edge_sel_q;
  logic [NUM_PINS-1:0] pend_q;
  logic [NUM_PINS-1:0] prev_q;
  logic [NUM_PINS-1:0] sync_q;
  logic [NUM_PINS-1:0] edge_det;
  logic [NUM_PINS-1:0] pend_clr;
  logic [NUM_PINS-1:0] w_pins;
  logic [NUM_PINS-1:0] rd_pins;
  logic [MXLEN-1:0]    rel_addr;
  logic                hit;
  logic                wr;
  reg_sel_e            sel;
  logic                unused_w_data;

  // Subtraction wraps addresses below the base to large values, so one
  // unsigned compare covers both ends of the window.
  assign rel_addr = addr - BASE_ADDR;
  assign hit      = (rel_addr < MXLEN'(WINDOW_BYTES)) && (addr[1:0] == 2'b00);
  assign sel      = reg_sel_e'(rel_addr[4:2]);
  assign wr       = store && hit;
  assign w_pins   = w_data[NUM_PINS-1:0];

  assign unused_w_data = ^w_data;

  gpio_sync #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (gpio_in),
    .q   (sync_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_q;
    end
  end

  assign edge_det = (sync_q & ~prev_q & ~edge_sel_q) | (~sync_q & prev_q & edge_sel_q);
  assign pend_clr = (wr && sel == REG_PEND) ? w_pins : '0;

  // A fresh edge wins over a W1C clear aimed at the same bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q      <= '0;
      dir_q      <= '0;
      ie_q       <= '0;
      edge_sel_q <= '0;
      pend_q     <= '0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | edge_det;
      if (wr) begin
        case (sel)
          REG_OUT:  out_q      <= w_pins;
          REG_DIR:  dir_q      <= w_pins;
          REG_IE:   ie_q       <= w_pins;
          REG_EDGE: edge_sel_q <= w_pins;
          REG_SET:  out_q      <= out_q | w_pins;
          REG_CLR:  out_q      <= out_q & ~w_pins;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    rd_pins = '0;
    case (sel)
      REG_OUT:  rd_pins = out_q;
      REG_DIR:  rd_pins = dir_q;
      REG_IN:   rd_pins = sync_q;
      REG_IE:   rd_pins = ie_q;
      REG_EDGE: rd_pins = edge_sel_q;
      REG_PEND: rd_pins = pend_q;
      default:  rd_pins = '0;
    endcase
    r_data = '0;
    if (load && hit) begin
      r_data = MXLEN'(rd_pins);
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(pend_q & ie_q);

endmodule
